// File: rtl/alu_arbiter_pkg.sv
// Shared ALU packet format, operation codes and arbiter state encoding.
// Imported by the arbiter, its picker and the ALU-side test model.
package alu_arbiter_pkg;

    localparam int unsigned REGISTER_SIZE = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4
    } alu_op_t;

    // Field order places the operation in the LSBs, so it is shifted out first.
    typedef struct packed {
        logic [REGISTER_SIZE-1:0] rs2;
        logic [REGISTER_SIZE-1:0] rs1;
        alu_op_t                  operation;
    } AluPacket;

    localparam int unsigned ALU_PACKET_BITS = $bits(AluPacket);

    typedef enum logic [7:0] {
        ST_IDLE        = 8'b0000_0001,
        ST_GRANT       = 8'b0000_0010,
        ST_START       = 8'b0000_0100,
        ST_SENDING     = 8'b0000_1000,
        ST_WAIT_RESULT = 8'b0001_0000,
        ST_RECEIVING   = 8'b0010_0000,
        ST_DONE        = 8'b0100_0000,
        ST_ABORT       = 8'b1000_0000
    } arb_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_if.sv
// Single-master SPI bundle; one active-low select line per slave.
interface Spi #(
    parameter int unsigned NUM_SLAVES = 1
);
    logic                  sclk;
    logic [NUM_SLAVES-1:0] nss;
    logic                  mosi;
    logic                  miso;

    modport master (output sclk, output nss, output mosi, input miso);
    modport slave  (input sclk, input nss, input mosi, output miso);
endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first request at or after
// the pointer wins, wrapping back to index 0.
module rr_picker #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_pointer,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_index,
    output logic             o_valid
);

    always_comb begin
        o_grant = '0;
        o_index = '0;
        o_valid = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_valid && i_req[i] && (i >= 32'(i_pointer))) begin
                o_valid    = 1'b1;
                o_grant[i] = 1'b1;
                o_index    = IDX_W'(i);
            end
        end
        // Wrapped pass: only reached when nothing at or above the pointer asked.
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_valid && i_req[i]) begin
                o_valid    = 1'b1;
                o_grant[i] = 1'b1;
                o_index    = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one serial ALU; runs the SPI master exchange
// for the granted requester and returns the result with a done pulse.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQUESTERS = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                                            i_clock,
    input  logic                                            i_reset,
    input  logic [NUM_REQUESTERS-1:0]                       i_req,
    input  logic [NUM_REQUESTERS-1:0][ALU_PACKET_BITS-1:0]  i_packet,
    output logic [NUM_REQUESTERS-1:0]                       o_grant,
    output logic [NUM_REQUESTERS-1:0]                       o_done,
    output logic [REGISTER_SIZE-1:0]                        o_result,
    output logic                                            o_timeout,
    Spi.master                                              spi
);

    localparam int unsigned IDX_W     = $clog2(NUM_REQUESTERS);
    localparam int unsigned PKT_IDX_W = $clog2(ALU_PACKET_BITS);
    localparam int unsigned RX_IDX_W  = $clog2(REGISTER_SIZE);
    localparam int unsigned BIT_W     = max_u(PKT_IDX_W, RX_IDX_W);
    localparam int unsigned TMO_W     = max_u(1, $clog2(TIMEOUT_CYCLES));

    arb_state_t                  state_q, state_d;
    logic [IDX_W-1:0]            ptr_q, ptr_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [NUM_REQUESTERS-1:0]   sel_q, sel_d;
    logic [ALU_PACKET_BITS-1:0]  packet_q, packet_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [TMO_W-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic [REGISTER_SIZE-1:0]    rx_q, rx_d;
    logic [NUM_REQUESTERS-1:0]   grant_q, grant_d;
    logic [NUM_REQUESTERS-1:0]   done_q, done_d;
    logic [REGISTER_SIZE-1:0]    result_q, result_d;
    logic                        timeout_q, timeout_d;

    logic [NUM_REQUESTERS-1:0]   pick_grant;
    logic [IDX_W-1:0]            pick_index;
    logic                        pick_valid;
    logic                        abort;

    rr_picker #(
        .N     (NUM_REQUESTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req     (i_req),
        .i_pointer (ptr_q),
        .o_grant   (pick_grant),
        .o_index   (pick_index),
        .o_valid   (pick_valid)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        sel_d     = sel_q;
        packet_d  = packet_q;
        bit_cnt_d = bit_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        rx_d      = rx_q;
        grant_d   = grant_q;
        done_d    = '0;
        result_d  = '0;
        timeout_d = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_index;
                    sel_d   = pick_grant;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                packet_d  = i_packet[idx_q];
                grant_d   = sel_q;
                tmo_cnt_d = '0;
                state_d   = ST_START;
            end
            ST_START: begin
                if (!spi.miso) begin
                    bit_cnt_d = '0;
                    state_d   = ST_SENDING;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_SENDING: begin
                if (bit_cnt_q == BIT_W'(ALU_PACKET_BITS - 1)) begin
                    bit_cnt_d = '0;
                    tmo_cnt_d = '0;
                    state_d   = ST_WAIT_RESULT;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_WAIT_RESULT: begin
                if (spi.miso) begin
                    bit_cnt_d = '0;
                    state_d   = ST_RECEIVING;
                end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_RECEIVING: begin
                rx_d[bit_cnt_q[RX_IDX_W-1:0]] = spi.miso;
                if (bit_cnt_q == BIT_W'(REGISTER_SIZE - 1)) begin
                    bit_cnt_d = '0;
                    result_d  = rx_d;
                    done_d    = grant_q;
                    grant_d   = '0;
                    state_d   = ST_DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_DONE, ST_ABORT: begin
                ptr_d   = (idx_q == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : idx_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            done_d    = grant_q;
            grant_d   = '0;
            timeout_d = 1'b1;
            state_d   = ST_ABORT;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            sel_q     <= '0;
            packet_q  <= '0;
            bit_cnt_q <= '0;
            tmo_cnt_q <= '0;
            rx_q      <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            sel_q     <= sel_d;
            packet_q  <= packet_d;
            bit_cnt_q <= bit_cnt_d;
            tmo_cnt_q <= tmo_cnt_d;
            rx_q      <= rx_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    // Select and data decode only from registered state, so the async reset
    // releases the bus immediately.
    always_comb begin
        spi.nss  = '1;
        spi.mosi = 1'b0;
        unique case (state_q)
            ST_START: begin
                spi.nss  = '0;
                spi.mosi = 1'b1;
            end
            ST_SENDING: begin
                spi.nss  = '0;
                spi.mosi = packet_q[bit_cnt_q[PKT_IDX_W-1:0]];
            end
            ST_WAIT_RESULT, ST_RECEIVING: spi.nss = '0;
            default: ;
        endcase
    end

    assign spi.sclk  = i_clock;
    assign o_grant   = grant_q;
    assign o_done    = done_q;
    assign o_result  = result_q;
    assign o_timeout = timeout_q;

endmodule
